counter_ctrl: RTL

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// Command-driven controller for an external up-counter: LOAD/START/STOP/CLEAR with terminal-count detection.
// Optional build macro COUNTER_CTRL_AUTORELOAD_EN: terminal count reloads and keeps running instead of returning to idle.
module counter_ctrl #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_LOAD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on a rising clk edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is low in LOAD and DONE and during reset.

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

`ifdef COUNTER_CTRL_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] w_next_term;
  logic [WIDTH-1:0] r_load_val;
  logic [WIDTH-1:0] w_next_load_val;
  logic             w_next_err;
  logic             w_accept;
  logic             w_match;

  logic             r_cmd_ready;
  logic             r_cnt_en;
  logic             r_cnt_load;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_next_cmd_ready;
  logic             w_next_cnt_en;
  logic             w_next_cnt_load;
  logic             w_next_busy;
  logic             w_next_done;

  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_match  = (cnt_value == r_term);

  always_comb begin
    w_next_state    = r_state;
    w_next_term     = r_term;
    w_next_load_val = r_load_val;
    w_next_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_LOAD: begin
              w_next_load_val = cmd_data;
              w_next_state    = S_LOAD;
            end
            OP_START: begin
              w_next_term  = cmd_data;
              w_next_state = S_RUN;
            end
            OP_CLEAR: begin
              w_next_load_val = DEFAULT_LOAD;
              w_next_state    = S_LOAD;
            end
            default: w_next_state = S_IDLE;
          endcase
        end
      end
      S_LOAD: w_next_state = S_IDLE;
      S_RUN: begin
        // Terminal match has priority; any command in the same cycle is dropped.
        if (w_match) begin
          w_next_state = S_DONE;
        end else if (w_accept) begin
          case (cmd_op)
            OP_STOP: w_next_state = S_IDLE;
            OP_CLEAR: begin
              w_next_load_val = DEFAULT_LOAD;
              w_next_state    = S_LOAD;
            end
            default: w_next_err = 1'b1;
          endcase
        end
      end
      S_DONE: w_next_state = AUTORELOAD ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with r_state.
  always_comb begin
    w_next_cmd_ready = (w_next_state == S_IDLE) || (w_next_state == S_RUN);
    w_next_cnt_en    = (w_next_state == S_RUN);
    w_next_cnt_load  = (w_next_state == S_LOAD) || (AUTORELOAD && (w_next_state == S_DONE));
    w_next_busy      = (w_next_state != S_IDLE);
    w_next_done      = (w_next_state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_term      <= '0;
      r_load_val  <= DEFAULT_LOAD;
      r_cmd_ready <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_cnt_load  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_term      <= w_next_term;
      r_load_val  <= w_next_load_val;
      r_cmd_ready <= w_next_cmd_ready;
      r_cnt_en    <= w_next_cnt_en;
      r_cnt_load  <= w_next_cnt_load;
      r_busy      <= w_next_busy;
      r_done      <= w_next_done;
      r_err       <= w_next_err;
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign cnt_en       = r_cnt_en;
  assign cnt_load     = r_cnt_load;
  assign cnt_load_val = r_load_val;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign dbg_state    = r_state;

endmodule
